pool_sched: RTL and testbench

- Sequencer for one `pooler` instance (M×M input map, P×P window).
- Streams C channel feature maps from the convolver output buffer into the pooler, one channel at a time.
- Clears the pooler between channels and writes each pooled result to the pool output buffer at sequential addresses.
- Sits between the convolver result RAM and the next layer's input RAM; started by the top-level layer controller.

---
 rtl/pool_sched_pkg.sv | 35 +++
 rtl/pool_sched_addr_gen.sv | 70 +++++++
 rtl/pool_sched.sv | 185 ++++++++++++++++++
 tb/tb_pool_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_sched_pkg.sv
// Shared definitions for the pooling sequencer: state encoding, derived
// sizes and the counter-width helper.
package pool_sched_pkg;

    localparam int DEF_M = 4;
    localparam int DEF_P = 2;
    localparam int DEF_C = 2;

    // Bits needed to hold the values 0 .. n-1 (never less than one bit).
    function automatic int cntWidth(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int calcNin(input int m);
        return m * m;
    endfunction

    function automatic int calcNout(input int m, input int p);
        return (m / p) * (m / p);
    endfunction

    // Sizes for the default geometry.
    localparam int NIN  = calcNin(DEF_M);
    localparam int NOUT = calcNout(DEF_M, DEF_P);

    // Sequencer states.
    typedef logic [2:0] state_t;
    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_CLR   = 3'd1;
    localparam state_t S_FEED  = 3'd2;
    localparam state_t S_DRAIN = 3'd3;
    localparam state_t S_NEXT  = 3'd4;
    localparam state_t S_FIN   = 3'd5;

endpackage

// File: rtl/pool_sched_addr_gen.sv
// Address generator: channel, input-pixel and output-write counters plus
// the source base-address arithmetic.
module pool_addr_gen
    import pool_sched_pkg::*;
#(
    parameter int M  = DEF_M,
    parameter int C  = DEF_C,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          master_rst_n,
    input  logic          i_start,
    input  logic          i_clrIn,
    input  logic          i_incIn,
    input  logic          i_incCh,
    input  logic          i_incWr,
    output logic [AW-1:0] o_rdAddr,
    output logic [AW-1:0] o_wrAddr,
    output logic          o_inLast,
    output logic          o_chLast
);

    localparam int N_IN = calcNin(M);
    localparam int IN_W = cntWidth(N_IN);
    localparam int CH_W = cntWidth(C);

    logic [CH_W-1:0] r_ch;
    logic [IN_W-1:0] r_inCnt;
    logic [AW-1:0]   r_wrAddr;

    // Channel index: restarts on each accepted start, steps between channels.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_ch <= '0;
        end else if (i_start) begin
            r_ch <= '0;
        end else if (i_incCh) begin
            r_ch <= r_ch + 1'b1;
        end
    end

    // Pixel index within the current channel.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_inCnt <= '0;
        end else if (i_clrIn) begin
            r_inCnt <= '0;
        end else if (i_incIn) begin
            r_inCnt <= r_inCnt + 1'b1;
        end
    end

    // Destination address runs on across channels and advances once the
    // write using it has been presented.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_wrAddr <= '0;
        end else if (i_start) begin
            r_wrAddr <= '0;
        end else if (i_incWr) begin
            r_wrAddr <= r_wrAddr + 1'b1;
        end
    end

    assign o_rdAddr = AW'(r_ch) * AW'(N_IN) + AW'(r_inCnt);
    assign o_wrAddr = r_wrAddr;
    assign o_inLast = (r_inCnt == IN_W'(N_IN - 1));
    assign o_chLast = (r_ch == CH_W'(C - 1));

endmodule

// File: rtl/pool_sched.sv
// Pooling sequencer: streams C channel maps from the convolver buffer into
// one pooler, clears it between channels and stores the pooled results.
module pool_sched
    import pool_sched_pkg::*;
#(
    parameter int M         = DEF_M,
    parameter int P         = DEF_P,
    parameter int C         = DEF_C,
    parameter int DW        = 32,
    parameter int AW        = 10,
    parameter int DRAIN_MAX = 64
) (
    input  logic          clk,
    input  logic          master_rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic          pool_rst,
    output logic          pool_ce,
    output logic [DW-1:0] pool_data_in,
    input  logic [DW-1:0] pool_data_out,
    input  logic          pool_valid,
    input  logic          pool_end,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data
);

    localparam int N_OUT = calcNout(M, P);
    localparam int OUT_W = cntWidth(N_OUT + 1);
    localparam int DR_W  = cntWidth(DRAIN_MAX);

    state_t          r_state;
    state_t          w_next;
    logic            r_busy;
    logic            r_err;
    logic            r_rdEnD;
    logic            r_wrEn;
    logic [DW-1:0]   r_wrData;
    logic [OUT_W-1:0] r_outCnt;
    logic [DR_W-1:0] r_drainCnt;

    logic            w_start;
    logic            w_capWin;
    logic            w_accept;
    logic            w_extra;
    logic [OUT_W-1:0] w_outNext;
    logic            w_endBad;
    logic            w_outDone;
    logic            w_timeout;
    logic            w_inLast;
    logic            w_chLast;

    assign w_start   = (r_state == S_IDLE) && start;
    assign w_capWin  = (r_state == S_FEED) || (r_state == S_DRAIN);
    assign w_outDone = (r_outCnt == OUT_W'(N_OUT));
    assign w_accept  = w_capWin && pool_valid && !w_outDone;
    assign w_extra   = w_capWin && pool_valid && w_outDone;
    assign w_outNext = r_outCnt + OUT_W'(w_accept);
    assign w_endBad  = w_capWin && pool_end && (w_outNext != OUT_W'(N_OUT));
    assign w_timeout = (r_state == S_DRAIN) && !w_outDone &&
                       (r_drainCnt == DR_W'(DRAIN_MAX - 1));

    pool_addr_gen #(
        .M  (M),
        .C  (C),
        .AW (AW)
    ) u_addrGen (
        .clk          (clk),
        .master_rst_n (master_rst_n),
        .i_start      (w_start),
        .i_clrIn      (r_state == S_CLR),
        .i_incIn      (r_state == S_FEED),
        .i_incCh      ((r_state == S_NEXT) && !w_chLast),
        .i_incWr      (r_wrEn),
        .o_rdAddr     (rd_addr),
        .o_wrAddr     (wr_addr),
        .o_inLast     (w_inLast),
        .o_chLast     (w_chLast)
    );

    // Next-state selection for the channel sequencing.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_CLR;
            S_CLR:   w_next = S_FEED;
            S_FEED:  if (w_inLast) w_next = S_DRAIN;
            S_DRAIN: begin
                if (w_outDone) begin
                    w_next = S_NEXT;
                end else if (w_timeout) begin
                    w_next = S_FIN;
                end
            end
            S_NEXT:  w_next = w_chLast ? S_FIN : S_CLR;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Busy spans from accepted start until the done cycle has passed.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_busy <= 1'b0;
        end else if (w_start) begin
            r_busy <= 1'b1;
        end else if (r_state == S_FIN) begin
            r_busy <= 1'b0;
        end
    end

    // Sticky error: timeout, surplus valid or an early/late pooler end.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_timeout || w_extra || w_endBad) begin
            r_err <= 1'b1;
        end
    end

    // Delayed read strobe marks the cycle the read data is at the pooler.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_rdEnD <= 1'b0;
        end else begin
            r_rdEnD <= rd_en;
        end
    end

    // Output and drain counters restart for every channel.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_outCnt   <= '0;
            r_drainCnt <= '0;
        end else if (r_state == S_CLR) begin
            r_outCnt   <= '0;
            r_drainCnt <= '0;
        end else begin
            r_outCnt <= w_outNext;
            if (r_state == S_DRAIN) begin
                r_drainCnt <= r_drainCnt + 1'b1;
            end
        end
    end

    // Captured pooler results are presented to the destination one cycle later.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_wrEn   <= 1'b0;
            r_wrData <= '0;
        end else begin
            r_wrEn <= w_accept;
            if (w_accept) begin
                r_wrData <= pool_data_out;
            end
        end
    end

    assign busy         = r_busy;
    assign done         = (r_state == S_FIN);
    assign err          = r_err;
    assign rd_en        = (r_state == S_FEED);
    assign pool_rst     = (r_state == S_CLR);
    assign pool_ce      = r_rdEnD || (r_state == S_DRAIN);
    assign pool_data_in = r_rdEnD ? rd_data : '0;
    assign wr_en        = r_wrEn;
    assign wr_data      = r_wrData;

endmodule

// File: tb/tb_pool_sched.sv
// Directed bench for pool_sched with a behavioural max-pool model.
module tb_pool_sched;
   import pool_sched_pkg::*;

   localparam int DW = 32;
   localparam int AW = 10;
   localparam int MM = DEF_M;
   localparam int PP = DEF_P;
   localparam int MODE_NORMAL = 0;
   localparam int MODE_NEVER  = 1;
   localparam int MODE_END3   = 2;
   localparam int LOG_N = 512;

   typedef struct {
      int mode;
      bit again;
      int expReads;
      int expWrites;
      int expErr;
      int expRst;
   } vec_t;

   logic          clk = 1'b0;
   logic          master_rst_n;
   logic          start;
   logic          busy, done, err, rd_en, pool_rst, pool_ce, wr_en;
   logic          pool_valid, pool_end;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [DW-1:0] rd_data, pool_data_in, pool_data_out, wr_data;

   int mode = MODE_NORMAL;
   int nChecks = 0;
   int nFails = 0;

   int rdLog [LOG_N];
   int wrAddrLog [LOG_N];
   int wrDataLog [LOG_N];
   int rdTotal = 0;
   int wrTotal = 0;
   int doneTotal = 0;
   int rstTotal = 0;
   int rstCeErr = 0;

   always #5 clk = ~clk;

   pool_sched dut (
      .clk           (clk),
      .master_rst_n  (master_rst_n),
      .start         (start),
      .busy          (busy),
      .done          (done),
      .err           (err),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .pool_rst      (pool_rst),
      .pool_ce       (pool_ce),
      .pool_data_in  (pool_data_in),
      .pool_data_out (pool_data_out),
      .pool_valid    (pool_valid),
      .pool_end      (pool_end),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data)
   );

   // Source RAM whose contents equal the address, one-cycle read latency.
   always @(posedge clk) begin
      if (rd_en) rd_data <= DW'(rd_addr);
   end

   function automatic logic [DW-1:0] nextMax(input bit first, input logic [DW-1:0] a,
                                             input logic [DW-1:0] d);
      return first ? d : ((d > a) ? d : a);
   endfunction

   // Behavioural max-pooler for raster-order input, stride equal to window.
   int pix, nVal;
   logic [DW-1:0] acc [MM/PP];
   always @(posedge clk or negedge master_rst_n) begin
      if (!master_rst_n) begin
         pix <= 0;
         nVal <= 0;
         pool_valid <= 1'b0;
         pool_end <= 1'b0;
         pool_data_out <= '0;
      end else if (pool_rst) begin
         pix <= 0;
         nVal <= 0;
         pool_valid <= 1'b0;
         pool_end <= 1'b0;
      end else begin
         pool_valid <= 1'b0;
         pool_end <= 1'b0;
         if (pool_ce && pix < NIN) begin
            pix <= pix + 1;
            acc[(pix % MM) / PP] <= nextMax(((pix / MM) % PP == 0) && ((pix % MM) % PP == 0),
                                            acc[(pix % MM) / PP], pool_data_in);
            if (((pix / MM) % PP == PP - 1) && ((pix % MM) % PP == PP - 1) && mode != MODE_NEVER) begin
               pool_valid <= 1'b1;
               pool_data_out <= nextMax(((pix / MM) % PP == 0) && ((pix % MM) % PP == 0),
                                        acc[(pix % MM) / PP], pool_data_in);
               pool_end <= (mode == MODE_END3) ? (nVal == 2) : (nVal == NOUT - 1);
               nVal <= nVal + 1;
            end
         end
      end
   end

   // Observation log sampled mid-cycle.
   always @(negedge clk) begin
      if (rd_en && rdTotal < LOG_N) begin
         rdLog[rdTotal] = int'(rd_addr);
         rdTotal = rdTotal + 1;
      end
      if (wr_en && wrTotal < LOG_N) begin
         wrAddrLog[wrTotal] = int'(wr_addr);
         wrDataLog[wrTotal] = int'(wr_data);
         wrTotal = wrTotal + 1;
      end
      if (done) doneTotal = doneTotal + 1;
      if (pool_rst) begin
         rstTotal = rstTotal + 1;
         if (pool_ce) rstCeErr = rstCeErr + 1;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks = nChecks + 1;
      if (act !== exp) begin
         nFails = nFails + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " strobes"}, 64'({busy, done, err, rd_en, pool_rst, pool_ce, wr_en}), 64'd0);
      checkOutput({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
      checkOutput({tag, " wr_addr"}, 64'(wr_addr), 64'd0);
      checkOutput({tag, " wr_data"}, 64'(wr_data), 64'd0);
      checkOutput({tag, " pool_data_in"}, 64'(pool_data_in), 64'd0);
   endtask

   // One start pulse, optional second start at cycle 10, wait for done.
   task automatic applyStimulus(input int m, input bit again, output int ceLat,
                                output bit busyN1, output bit gotDone);
      int cnt;
      mode = m;
      ceLat = -1;
      busyN1 = 1'b0;
      gotDone = 1'b0;
      @(negedge clk);
      start = 1'b1;
      cnt = 0;
      while (!gotDone && cnt < 400) begin
         @(negedge clk);
         cnt = cnt + 1;
         start = again && (cnt == 10);
         if (cnt == 1) busyN1 = busy;
         if (pool_ce && ceLat < 0) ceLat = cnt;
         if (done) gotDone = 1'b1;
      end
      start = 1'b0;
   endtask

   vec_t vecs [4];
   int expWr [8];

   initial begin
      int ceLat, rdBase, wrBase, doneBase, rstBase, rstCeBase, badOrder, ch1Reads, waitCnt;
      bit busyN1, gotDone;
      vecs[0] = '{MODE_NORMAL, 1'b0, 2 * NIN, 2 * NOUT, 0, 2};
      vecs[1] = '{MODE_NORMAL, 1'b1, 2 * NIN, 2 * NOUT, 0, 2};
      vecs[2] = '{MODE_NEVER,  1'b0, NIN,     0,        1, 1};
      vecs[3] = '{MODE_END3,   1'b0, 2 * NIN, 2 * NOUT, 1, 2};
      expWr = '{5, 7, 13, 15, 21, 23, 29, 31};

      master_rst_n = 1'b0;
      start = 1'b0;
      #23;
      checkIdle("reset");
      @(negedge clk);
      master_rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 4; v++) begin
         rdBase = rdTotal;
         wrBase = wrTotal;
         doneBase = doneTotal;
         rstBase = rstTotal;
         rstCeBase = rstCeErr;
         applyStimulus(vecs[v].mode, vecs[v].again, ceLat, busyN1, gotDone);
         checkOutput($sformatf("v%0d done seen", v), 64'(gotDone), 64'd1);
         @(negedge clk);
         @(negedge clk);
         checkOutput($sformatf("v%0d busy start", v), 64'(busyN1), 64'd1);
         checkOutput($sformatf("v%0d ce latency", v), 64'(ceLat), 64'd3);
         checkOutput($sformatf("v%0d busy after", v), 64'(busy), 64'd0);
         checkOutput($sformatf("v%0d err", v), 64'(err), 64'(vecs[v].expErr));
         checkOutput($sformatf("v%0d done pulses", v), 64'(doneTotal - doneBase), 64'd1);
         checkOutput($sformatf("v%0d reads", v), 64'(rdTotal - rdBase), 64'(vecs[v].expReads));
         checkOutput($sformatf("v%0d writes", v), 64'(wrTotal - wrBase), 64'(vecs[v].expWrites));
         checkOutput($sformatf("v%0d pool_rst cycles", v), 64'(rstTotal - rstBase), 64'(vecs[v].expRst));
         checkOutput($sformatf("v%0d ce during rst", v), 64'(rstCeErr - rstCeBase), 64'd0);
         badOrder = 0;
         ch1Reads = 0;
         for (int i = 0; i < rdTotal - rdBase; i++) begin
            if (rdLog[rdBase + i] != i) badOrder = badOrder + 1;
            if (rdLog[rdBase + i] >= NIN) ch1Reads = ch1Reads + 1;
         end
         checkOutput($sformatf("v%0d read order", v), 64'(badOrder), 64'd0);
         checkOutput($sformatf("v%0d ch1 reads", v), 64'(ch1Reads), 64'(vecs[v].expReads - NIN));
         for (int i = 0; i < wrTotal - wrBase && i < 8; i++) begin
            checkOutput($sformatf("v%0d wr%0d addr", v, i), 64'(wrAddrLog[wrBase + i]), 64'(i));
            checkOutput($sformatf("v%0d wr%0d data", v, i), 64'(wrDataLog[wrBase + i]), 64'(expWr[i]));
         end
      end

      // Asynchronous reset during channel 1 feed, then a full replay.
      doneBase = doneTotal;
      mode = MODE_NORMAL;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitCnt = 0;
      while (!(rd_en && rd_addr == AW'(NIN + 4)) && waitCnt < 200) begin
         @(negedge clk);
         waitCnt = waitCnt + 1;
      end
      checkOutput("reach ch1 feed", 64'(waitCnt < 200), 64'd1);
      #2;
      master_rst_n = 1'b0;
      #1;
      checkIdle("midrun reset");
      @(negedge clk);
      @(negedge clk);
      checkOutput("midrun no done", 64'(doneTotal - doneBase), 64'd0);
      master_rst_n = 1'b1;
      @(negedge clk);

      rdBase = rdTotal;
      wrBase = wrTotal;
      doneBase = doneTotal;
      applyStimulus(MODE_NORMAL, 1'b0, ceLat, busyN1, gotDone);
      @(negedge clk);
      checkOutput("replay done", 64'(gotDone), 64'd1);
      checkOutput("replay first rd", 64'(rdLog[rdBase]), 64'd0);
      checkOutput("replay reads", 64'(rdTotal - rdBase), 64'(2 * NIN));
      checkOutput("replay writes", 64'(wrTotal - wrBase), 64'(2 * NOUT));
      checkOutput("replay err", 64'(err), 64'd0);
      checkOutput("replay done pulses", 64'(doneTotal - doneBase), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
